// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard/forwarding unit: forwarding-mux selects and MDU tracker states.
package hazard_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;
  localparam logic [1:0] FWD_MD = 2'b11;

  typedef enum logic [1:0] {
    MD_IDLE    = 2'd0,
    MD_BUSY    = 2'd1,
    MD_WB_WAIT = 2'd2
  } md_state_e;

endpackage

// File: rtl/md_tracker.sv
// Tracks the single in-flight multi-cycle MDU op: countdown, pending destination and
// arbitration of the regfile write port against the W stage (W always wins).
module md_tracker
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int MD_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MdStartE,
  input  logic [REG_AW-1:0] WriteRegE,
  input  logic              RegWriteW,
  output logic              MdBusy,
  output logic              MdWb,
  output logic [REG_AW-1:0] MdDst
);

  localparam logic [3:0] CNT_INIT = 4'(MD_LAT - 1);

  md_state_e         state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [REG_AW-1:0] md_dst_q, md_dst_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    md_dst_d = md_dst_q;
    case (state_q)
      MD_IDLE: begin
        if (MdStartE) begin
          state_d  = MD_BUSY;
          cnt_d    = CNT_INIT;
          md_dst_d = WriteRegE;
        end
      end
      MD_BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (RegWriteW) begin
          state_d = MD_WB_WAIT;
        end else begin
          state_d = MD_IDLE;
        end
      end
      MD_WB_WAIT: begin
        if (!RegWriteW) begin
          state_d = MD_IDLE;
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= MD_IDLE;
      cnt_q    <= 4'd0;
      md_dst_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      md_dst_q <= md_dst_d;
    end
  end

  // The result is ready once the count has expired; it only commits if W leaves the port free.
  assign MdBusy = (state_q != MD_IDLE);
  assign MdWb   = !RegWriteW &&
                  (((state_q == MD_BUSY) && (cnt_q == 4'd0)) || (state_q == MD_WB_WAIT));
  assign MdDst  = md_dst_q;

endmodule

// File: rtl/hazard_md_unit.sv
// Hazard/forwarding unit for the 5-stage core with a multi-cycle MDU.
// Define HAZ_PERF_CNT_EN to build the StallCnt/FlushCnt performance counters.
module hazard_md_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWriteD,
  input  logic              RegWriteE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              MemtoRegE,
  input  logic              MemtoRegM,
  input  logic              BranchD,
  input  logic              JumpD,
  input  logic              MdOpD,
  input  logic              MdStartE,
  input  logic [REG_AW-1:0] RsD,
  input  logic [REG_AW-1:0] RtD,
  input  logic [REG_AW-1:0] RsE,
  input  logic [REG_AW-1:0] RtE,
  input  logic [REG_AW-1:0] WriteRegD,
  input  logic [REG_AW-1:0] WriteRegE,
  input  logic [REG_AW-1:0] WriteRegM,
  input  logic [REG_AW-1:0] WriteRegW,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              ForwardAD,
  output logic              ForwardBD,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushE,
  output logic              MdBusy,
  output logic              MdWb,
  output logic [REG_AW-1:0] MdDst,
  output logic [CNT_W-1:0]  StallCnt,
  output logic [CNT_W-1:0]  FlushCnt
);

  logic lwstall, brstall, mdstall, stall;

  md_tracker #(
    .REG_AW(REG_AW),
    .MD_LAT(MD_LAT)
  ) u_md_tracker (
    .clk      (clk),
    .rst      (rst),
    .MdStartE (MdStartE),
    .WriteRegE(WriteRegE),
    .RegWriteW(RegWriteW),
    .MdBusy   (MdBusy),
    .MdWb     (MdWb),
    .MdDst    (MdDst)
  );

  // Youngest producer wins: M over W over the MDU result being written this cycle.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] src,
    input logic [REG_AW-1:0] wr_m,
    input logic              we_m,
    input logic [REG_AW-1:0] wr_w,
    input logic              we_w,
    input logic [REG_AW-1:0] md_dst,
    input logic              md_wb
  );
    if (src == '0)                    return FWD_RF;
    if ((src == wr_m) && we_m)        return FWD_M;
    if ((src == wr_w) && we_w)        return FWD_W;
    if ((src == md_dst) && md_wb)     return FWD_MD;
    return FWD_RF;
  endfunction

  always_comb begin
    ForwardAE = fwd_sel(RsE, WriteRegM, RegWriteM, WriteRegW, RegWriteW, MdDst, MdWb);
    ForwardBE = fwd_sel(RtE, WriteRegM, RegWriteM, WriteRegW, RegWriteW, MdDst, MdWb);
    ForwardAD = (RsD != '0) && (RsD == WriteRegM) && RegWriteM;
    ForwardBD = (RtD != '0) && (RtD == WriteRegM) && RegWriteM;

    lwstall = MemtoRegE && (RtE != '0) && ((RsD == RtE) || (RtD == RtE));
    brstall = BranchD &&
              ((RegWriteE && (WriteRegE != '0) && ((WriteRegE == RsD) || (WriteRegE == RtD))) ||
               (MemtoRegM && (WriteRegM != '0) && ((WriteRegM == RsD) || (WriteRegM == RtD))));
    // One MDU op at a time; also hold readers and writers of the pending destination.
    mdstall = MdBusy && (MdOpD || ((MdDst != '0) &&
              ((RsD == MdDst) || (RtD == MdDst) || (RegWriteD && (WriteRegD == MdDst)))));

    stall  = lwstall || brstall || mdstall;
    StallF = stall;
    StallD = stall;
    FlushE = stall || JumpD;
  end

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (StallD) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (FlushE) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCnt = stall_cnt_q;
  assign FlushCnt = flush_cnt_q;
`else
  assign StallCnt = '0;
  assign FlushCnt = '0;
`endif

endmodule
